signed_iter_divider: RTL and testbench



---
 rtl/div_pkg.sv | 25 ++
 rtl/div_iter_step.sv | 28 ++
 rtl/signed_iter_divider.sv | 150 +++++++++++++++
 tb/tb_signed_iter_divider.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : div_pkg                                                   |
// | Brief    : Shared FSM encoding and sizing for the iterative divider  |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
package div_pkg;

    localparam int c_DIV_IN_WD_DEF = 32;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        PREP = 3'd1,
        ITER = 3'd2,
        FIX  = 3'd3,
        DONE = 3'd4
    } div_state_e;

    // Radix-2: one quotient bit per iteration.
    function automatic int iter_num(input int wd);
        return wd;
    endfunction

endpackage
`default_nettype wire

// File: rtl/div_iter_step.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : div_iter_step                                             |
// | Brief    : One combinational restoring shift/subtract division step  |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module div_iter_step #(
    parameter int DIV_IN_WD = 32
) (
    input  logic [DIV_IN_WD-1:0] i_rem,
    input  logic                 i_bit,
    input  logic [DIV_IN_WD-1:0] i_div,
    output logic [DIV_IN_WD-1:0] o_rem,
    output logic                 o_q
);

    logic [DIV_IN_WD:0]   w_partial;
    logic [DIV_IN_WD-1:0] w_diff;

    assign w_partial = {i_rem, i_bit};
    assign o_q       = (w_partial >= {1'b0, i_div});
    // When the subtract succeeds the true difference is below the divisor,
    // so the low DIV_IN_WD bits of the modular difference are exact.
    assign w_diff    = w_partial[DIV_IN_WD-1:0] - i_div;
    assign o_rem     = o_q ? w_diff : w_partial[DIV_IN_WD-1:0];

endmodule
`default_nettype wire

// File: rtl/signed_iter_divider.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : signed_iter_divider                                       |
// | Brief    : Multi-cycle signed truncating divider, quotient+remainder |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module signed_iter_divider
    import div_pkg::*;
#(
    parameter int DIV_IN_WD = c_DIV_IN_WD_DEF,
    parameter int ITER_NUM  = iter_num(DIV_IN_WD)
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 val_i,
    input  logic [DIV_IN_WD-1:0] ai,
    input  logic [DIV_IN_WD-1:0] bi,
    output logic                 rdy_o,
    output logic                 val_o,
    output logic [DIV_IN_WD-1:0] quo_o,
    output logic [DIV_IN_WD-1:0] rem_o,
    output logic                 dz_o
);

    localparam int c_CNT_W = $clog2(ITER_NUM + 1);

    div_state_e           r_state;
    div_state_e           w_state_nxt;

    logic [DIV_IN_WD-1:0] r_a;
    logic [DIV_IN_WD-1:0] r_b;
    logic                 r_sa;
    logic                 r_sb;
    logic                 r_dz;
    logic [DIV_IN_WD-1:0] r_abs_b;
    logic [DIV_IN_WD-1:0] r_quo;
    logic [DIV_IN_WD-1:0] r_rem;
    logic [c_CNT_W-1:0]   r_cnt;

    logic                 r_val_o;
    logic [DIV_IN_WD-1:0] r_quo_o;
    logic [DIV_IN_WD-1:0] r_rem_o;
    logic                 r_dz_o;

    logic                 w_dz;
    logic                 w_last;
    logic [DIV_IN_WD-1:0] w_abs_a;
    logic [DIV_IN_WD-1:0] w_abs_b;
    logic [DIV_IN_WD-1:0] w_step_rem;
    logic                 w_step_q;

    // Negating the most negative value wraps to itself, which read as
    // unsigned is exactly its magnitude.
    assign w_abs_a = r_a[DIV_IN_WD-1] ? -r_a : r_a;
    assign w_abs_b = r_b[DIV_IN_WD-1] ? -r_b : r_b;
    assign w_dz    = (r_b == '0);
    assign w_last  = (r_cnt == c_CNT_W'(ITER_NUM - 1));

    div_iter_step #(
        .DIV_IN_WD (DIV_IN_WD)
    ) u_step (
        .i_rem (r_rem),
        .i_bit (r_quo[DIV_IN_WD-1]),
        .i_div (r_abs_b),
        .o_rem (w_step_rem),
        .o_q   (w_step_q)
    );

    always_ff @(posedge clk) begin
        if (rstn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (val_i) w_state_nxt = PREP;
            PREP:    w_state_nxt = w_dz ? DONE : ITER;
            ITER:    if (w_last) w_state_nxt = FIX;
            FIX:     w_state_nxt = DONE;
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rstn) begin
            r_a     <= '0;
            r_b     <= '0;
            r_sa    <= 1'b0;
            r_sb    <= 1'b0;
            r_dz    <= 1'b0;
            r_abs_b <= '0;
            r_quo   <= '0;
            r_rem   <= '0;
            r_cnt   <= '0;
            r_val_o <= 1'b0;
            r_quo_o <= '0;
            r_rem_o <= '0;
            r_dz_o  <= 1'b0;
        end else begin
            r_val_o <= (r_state == DONE);
            case (r_state)
                IDLE: begin
                    if (val_i) begin
                        r_a <= ai;
                        r_b <= bi;
                    end
                end
                PREP: begin
                    r_sa    <= r_a[DIV_IN_WD-1];
                    r_sb    <= r_b[DIV_IN_WD-1];
                    r_abs_b <= w_abs_b;
                    r_dz    <= w_dz;
                    r_cnt   <= '0;
                    // r_quo doubles as the dividend shift register; a zero
                    // divisor preloads the final all-ones/dividend result.
                    r_quo   <= w_dz ? '1 : w_abs_a;
                    r_rem   <= w_dz ? r_a : '0;
                end
                ITER: begin
                    r_quo <= {r_quo[DIV_IN_WD-2:0], w_step_q};
                    r_rem <= w_step_rem;
                    r_cnt <= r_cnt + 1'b1;
                end
                FIX: begin
                    if (r_sa ^ r_sb) r_quo <= -r_quo;
                    if (r_sa)        r_rem <= -r_rem;
                end
                DONE: begin
                    r_quo_o <= r_quo;
                    r_rem_o <= r_rem;
                    r_dz_o  <= r_dz;
                end
                default: ;
            endcase
        end
    end

    assign rdy_o = (r_state == IDLE);
    assign val_o = r_val_o;
    assign quo_o = r_quo_o;
    assign rem_o = r_rem_o;
    assign dz_o  = r_dz_o;

endmodule
`default_nettype wire

// File: tb/tb_signed_iter_divider.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_signed_iter_divider                                    |
// | Brief    : Directed scoreboard bench for signed_iter_divider         |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module tb_signed_iter_divider;

    localparam int W = 32;

    logic         clk;
    logic         rstn;
    logic         val_i;
    logic [W-1:0] ai;
    logic [W-1:0] bi;
    logic         rdy_o;
    logic         val_o;
    logic [W-1:0] quo_o;
    logic [W-1:0] rem_o;
    logic         dz_o;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dz;
        int           acc;
        int           lat;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    bit   prev_val = 1'b0;

    signed_iter_divider #(
        .DIV_IN_WD (W)
    ) dut (
        .clk   (clk),
        .rstn  (rstn),
        .val_i (val_i),
        .ai    (ai),
        .bi    (bi),
        .rdy_o (rdy_o),
        .val_o (val_o),
        .quo_o (quo_o),
        .rem_o (rem_o),
        .dz_o  (dz_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual 0x%h required 0x%h", name, act, req);
        end
    endtask

    // Monitor: every val_o pulse is matched against the oldest expectation.
    always @(negedge clk) begin
        if (val_o) begin
            check("val_single_pulse", {31'b0, prev_val}, 32'd0);
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_val: actual val_o=1 required no result pending (cycle %0d)", cyc);
            end else begin
                mon_e = exp_q.pop_front();
                check("quo", quo_o, mon_e.q);
                check("rem", rem_o, mon_e.r);
                check("dz", {31'b0, dz_o}, {31'b0, mon_e.dz});
                check("latency", 32'(cyc - mon_e.acc), 32'(mon_e.lat));
            end
        end
        prev_val = val_o;
    end

    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input bit push,
                         input logic [W-1:0] eq, input logic [W-1:0] er, input logic edz,
                         input int elat);
        int guard = 0;
        @(negedge clk);
        while (!rdy_o && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (!rdy_o) begin
            n_checks++;
            n_fail++;
            $display("FAIL rdy_timeout: actual rdy_o=0 required rdy_o=1 within 200 cycles");
        end
        val_i = 1'b1;
        ai    = a;
        bi    = b;
        if (push) exp_q.push_back('{q: eq, r: er, dz: edz, acc: cyc + 1, lat: elat});
        @(negedge clk);
        val_i = 1'b0;
    endtask

    task automatic drain();
        int guard = 0;
        while (exp_q.size() != 0 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (exp_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain_timeout: actual %0d results pending required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic check_idle_zero(input string tag);
        check({tag, "_rdy"}, {31'b0, rdy_o}, 32'd1);
        check({tag, "_val"}, {31'b0, val_o}, 32'd0);
        check({tag, "_quo"}, quo_o, 32'd0);
        check({tag, "_rem"}, rem_o, 32'd0);
        check({tag, "_dz"},  {31'b0, dz_o}, 32'd0);
    endtask

    initial begin
        rstn  = 1'b1;
        val_i = 1'b0;
        ai    = '0;
        bi    = '0;
        repeat (3) @(negedge clk);
        check_idle_zero("reset");
        rstn = 1'b0;

        // 100/7 with a stray 9/3 strobe while busy
        issue(32'd100, 32'd7, 1'b1, 32'd14, 32'd2, 1'b0, 35);
        repeat (4) @(negedge clk);
        check("busy_rdy", {31'b0, rdy_o}, 32'd0);
        val_i = 1'b1;
        ai    = 32'd9;
        bi    = 32'd3;
        @(negedge clk);
        val_i = 1'b0;
        issue(32'd9, 32'd3, 1'b1, 32'd3, 32'd0, 1'b0, 35);

        issue(-32'sd100, 32'd7,    1'b1, -32'sd14, -32'sd2, 1'b0, 35);
        issue(32'd100,   -32'sd7,  1'b1, -32'sd14, 32'd2,   1'b0, 35);
        issue(32'd100,   32'd0,    1'b1, 32'hFFFF_FFFF, 32'd100, 1'b1, 2);
        issue(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'd0, 1'b0, 35);
        drain();

        // Abort 100/7 at iteration 10; val_i during reset must be dropped
        issue(32'd100, 32'd7, 1'b0, 32'd0, 32'd0, 1'b0, 0);
        repeat (10) @(negedge clk);
        rstn  = 1'b1;
        val_i = 1'b1;
        ai    = 32'd1;
        bi    = 32'd1;
        @(negedge clk);
        rstn  = 1'b0;
        val_i = 1'b0;
        check_idle_zero("abort");
        repeat (45) @(negedge clk);

        issue(32'd50, 32'd5, 1'b1, 32'd10, 32'd0, 1'b0, 35);
        drain();
        repeat (3) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
